input_conditioner: RTL
======================

Name: input_conditioner

Overview:
- Upstream front end for the 8-bit serial multiplier datapath.
- Takes raw active-low push buttons and slide switches from the board pins.
- Synchronizes all inputs to Clk and debounces every button.
- Emits clean debounced levels plus single-cycle press/release pulses, which drive Run and ClearA_LoadB. Also provides synchronized SW for the operand bus.

Parameters:
N_KEYS, 2, number of debounced push buttons (bit 0 = Run, bit 1 = ClearA_LoadB)
SW_WIDTH, 8, slide-switch bus width
DEBOUNCE_CYCLES, 250000, synchronized cycles a key must hold a new value before it is accepted (5 ms at 50 MHz); must be >= 2

Ports:
Clk  in  1  system clock, 50 MHz
Reset  in  1  synchronous, active-low reset
Key_n  in  N_KEYS  raw buttons, active-low (0 = pressed), asynchronous to Clk
SW_raw  in  SW_WIDTH  raw slide switches, asynchronous
Key_level  out  N_KEYS  debounced state, active-high (1 = pressed)
Key_press  out  N_KEYS  one-Clk pulse on accepted press
Key_release  out  N_KEYS  one-Clk pulse on accepted release
SW_sync  out  SW_WIDTH  two-flop synchronized switches

Behaviour:
- All state updates on rising Clk. Reset is sampled only at a rising edge while Reset == 0.
- Reset values:
  - Key sync flops = 1 (released).
  - SW sync flops = 0.
  - Counters = 0.
  - Key_level = 0, Key_press = 0, Key_release = 0, SW_sync = 0.
- Synchronizer: two flops per input bit; no metastability logic beyond that. SW path has 2-edge latency and no debounce.
- Per-key debounce: s = inverted output of the second sync flop (1 = pressed).
  - If s == Key_level: cnt <= 0.
  - If s != Key_level and cnt != DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - If s != Key_level and cnt == DEBOUNCE_CYCLES-1: Key_level <= s and cnt <= 0.
  - On the same edge, Key_press <= s and Key_release <= ~s.
- Pulses are registered and high for exactly one cycle, coincident with the first cycle of the new Key_level. Otherwise they are 0.
- Latency: Key_level changes on the (DEBOUNCE_CYCLES+2)th rising edge, counting the first edge that samples the new raw value as edge 1.
- Glitch rejection: any excursion shorter than DEBOUNCE_CYCLES synchronized cycles clears cnt on return. No level change, no pulse.
- Bounce: each return to the accepted level restarts the count. A bounce burst followed by a stable value yields exactly one pulse.
- Keys are fully independent. Simultaneous presses give simultaneous pulses on separate bits.
- Counter width is $clog2(DEBOUNCE_CYCLES). The counter never wraps, because it clears on accept.
- Reset mid-debounce: counter, level and pulses clear. A key still held after reset deasserts is treated as a new press and pulses after the full latency.
- Key_press and Key_release are never both high for the same bit.

Decomposition:
- Package input_pkg holds:
  - localparam KEY_RUN = 0 and KEY_CLEAR_LOAD = 1 (bit indices).
  - Default DEBOUNCE_CYCLES_SYN = 250000.
  - DEBOUNCE_CYCLES_SIM = 4, used by benches.
- Sub-module debounce_cell: one key covering sync, counter, level, press and release. input_conditioner instantiates N_KEYS copies in a generate loop, plus the SW synchronizer inline.

Test Plan:
All scenarios use DEBOUNCE_CYCLES = 4 and all keys released unless stated.
1. Reset = 0 for 3 edges, SW_raw = 8'hFF -> all outputs 0. After release, SW_sync = 8'hFF on the 2nd edge.
2. Key_n[0] driven 0 and held 20 cycles -> Key_level[0] = 1 from the 6th edge. Key_press[0] = 1 for exactly that one cycle. Key_release = 0. Key_level[1] = 0.
3. Key_n[1] low for 3 cycles then high -> Key_level[1], Key_press[1], Key_release[1] stay 0 throughout.
4. Key_n[0] toggles every cycle for 10 cycles, then is held 0 -> exactly one Key_press[0] pulse, 6 edges after the hold begins.
5. After scenario 2, Key_n[0] returns to 1 -> Key_release[0] single pulse and Key_level[0] = 0 on the 6th edge. No Key_press.
6. Key_n[0] held 0; Reset asserted for 1 edge after 3 edges of counting -> outputs cleared. Key_press[0] pulses on the 6th edge after Reset returns to 1.

Source files
------------

// File: rtl/input_pkg.sv
// input_pkg
// Shared constants for the multiplier input front end: key bit indices,
// debounce lengths for silicon and for simulation, and the counter-width
// helper used by the debounce cells.
package input_pkg;

  // Bit positions inside the Key_* buses.
  localparam int KEY_RUN        = 0;
  localparam int KEY_CLEAR_LOAD = 1;

  // 5 ms at 50 MHz for the board; a short window keeps benches fast.
  localparam int DEBOUNCE_CYCLES_SYN = 250000;
  localparam int DEBOUNCE_CYCLES_SIM = 4;

  // Counter only needs to reach cycles-1, so $clog2(cycles) bits suffice.
  // Guarded so a degenerate value never yields a zero-width vector.
  function automatic int cnt_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// debounce_cell
// One push button: two-flop synchronizer, stability counter, accepted
// level and registered single-cycle press/release pulses.
//
// Ports:
//   clk_i      system clock
//   rst_n_i    synchronous active-low reset
//   key_n_i    raw button, active-low, asynchronous to clk_i
//   level_o    debounced level, 1 = pressed
//   press_o    one-cycle pulse on the first cycle of an accepted press
//   release_o  one-cycle pulse on the first cycle of an accepted release
module debounce_cell
  import input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SYN
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int              CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q;
  logic             sync_q;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             level_q,   level_d;
  logic             press_q,   press_d;
  logic             release_q, release_d;
  logic             pressed;

  assign pressed = ~sync_q;

  // The counter only runs while the synchronized input disagrees with the
  // accepted level; any agreement restarts the window, so bounces and
  // short glitches never reach the output. Accept clears it, so no wrap.
  always_comb begin
    cnt_d     = '0;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (pressed != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d   = pressed;
        press_d   = pressed;
        release_d = ~pressed;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      meta_q    <= 1'b1;
      sync_q    <= 1'b1;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      meta_q    <= key_n_i;
      sync_q    <= meta_q;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/input_conditioner.sv
// input_conditioner
// Board-pin front end for the serial multiplier: debounces the push
// buttons (Run, ClearA_LoadB) and synchronizes the slide switches that
// feed the operand bus.
//
// Ports:
//   Clk          system clock, 50 MHz
//   Reset        synchronous active-low reset
//   Key_n        raw buttons, active-low, asynchronous
//   SW_raw       raw slide switches, asynchronous
//   Key_level    debounced key state, 1 = pressed
//   Key_press    one-cycle pulse per accepted press
//   Key_release  one-cycle pulse per accepted release
//   SW_sync      two-flop synchronized switches (no debounce)
module input_conditioner
  import input_pkg::*;
#(
  parameter int N_KEYS          = 2,
  parameter int SW_WIDTH        = 8,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SYN
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [N_KEYS-1:0]   Key_n,
  input  logic [SW_WIDTH-1:0] SW_raw,
  output logic [N_KEYS-1:0]   Key_level,
  output logic [N_KEYS-1:0]   Key_press,
  output logic [N_KEYS-1:0]   Key_release,
  output logic [SW_WIDTH-1:0] SW_sync
);

  logic [SW_WIDTH-1:0] sw_meta_q;
  logic [SW_WIDTH-1:0] sw_sync_q;

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clk_i    (Clk),
      .rst_n_i  (Reset),
      .key_n_i  (Key_n[k]),
      .level_o  (Key_level[k]),
      .press_o  (Key_press[k]),
      .release_o(Key_release[k])
    );
  end

  // Switches are static settings; a plain two-flop synchronizer is enough.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= SW_raw;
      sw_sync_q <= sw_meta_q;
    end
  end

  assign SW_sync = sw_sync_q;

endmodule
